// File: rtl/fpu_pkg.sv
// Shared FPU types: exception codes, rounding modes, FSM encodings and
// special-value constructors usable at any EXP_W/MAN_W.
package fpu_pkg;

  typedef enum logic [2:0] {
    EXC_NORMAL    = 3'b000,
    EXC_ZERO      = 3'b001,
    EXC_UNDERFLOW = 3'b010,
    EXC_NAN       = 3'b011,
    EXC_INF       = 3'b100
  } exc_t;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_MUL   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Encodings are built right-aligned in 64 bits; callers truncate to W.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int unsigned exp_w,
                                         input int unsigned man_w);
    return (64'(sign) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

  function automatic logic [63:0] fp_max(input logic sign, input int unsigned exp_w,
                                         input int unsigned man_w);
    return (64'(sign) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd2) << man_w)
           | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_mult_seq_if.sv
// Request/result handshake bundle between an FPU client and fp_mult_seq.
interface fp_mult_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic [W-1:0] Datain1;
  logic [W-1:0] Datain2;
  logic         Data_valid;
  logic [1:0]   Mode;
  logic [W-1:0] Dataout;
  logic         Dataout_valid;
  logic [2:0]   Exc;
  logic         Busy;

  modport master (
    output Datain1, Datain2, Data_valid, Mode,
    input  Dataout, Dataout_valid, Exc, Busy
  );

  modport slave (
    input  Datain1, Datain2, Data_valid, Mode,
    output Dataout, Dataout_valid, Exc, Busy
  );
endinterface

// File: rtl/seq_mant_mult.sv
// Iterative LSB-first shift-add multiplier: one partial product per cycle,
// done_o pulses for one cycle once all N multiplier bits have been consumed.
module seq_mant_mult #(
  parameter int unsigned N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);
  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  logic [PW-1:0] mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  // A new start always wins, discarding any stale computation.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start_i) begin
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;
endmodule

// File: rtl/fp_mult_seq.sv
// Multi-cycle floating-point multiplier controller: classify, iterate the
// mantissa product, normalise, round, and hold the result on a valid handshake.
module fp_mult_seq
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic         CLK,
  input  logic         RSTn,
  fp_mult_seq_if.slave bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned N    = MAN_W + 1;
  localparam int unsigned PW   = 2 * N;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  rmode_t           mode_q, mode_d;
  logic             sign_q, sign_d;
  logic [EW-1:0]    exp_q, exp_d;
  logic [MAN_W-1:0] frac_q, frac_d;
  logic             g_q, g_d, r_q, r_d, s_q, s_d;
  logic [W-1:0]     res_q, res_d, dout_q, dout_d;
  exc_t             exc_q, exc_d, xo_q, xo_d;
  logic             dv_q, dv_d, busy_q, busy_d;

  logic             mul_start, mul_done;
  logic [PW-1:0]    mul_prod;

  seq_mant_mult #(.N(N)) u_mant (
    .clk     (CLK),
    .rst_n   (RSTn),
    .start_i (mul_start),
    .a_i     ({1'b1, bus.Datain1[MAN_W-1:0]}),
    .b_i     ({1'b1, bus.Datain2[MAN_W-1:0]}),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Operand classification; subnormals (exp==0) are treated as zero.
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EW-1:0]    exp_sum;
  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == '1) && (fa == '0);
  assign b_inf   = (eb == '1) && (fb == '0);
  assign a_nan   = (ea == '1) && (fa != '0);
  assign b_nan   = (eb == '1) && (fb != '0);
  assign exp_sum = EW'(ea) + EW'(eb) - EW'(BIAS);

  // Rounding increment and post-round range checks; exp_q is two's complement.
  logic             inc, carry, ovf, unf, to_inf;
  logic [MAN_W-1:0] frac_rnd;
  logic [EW-1:0]    exp_rnd;
  always_comb begin
    inc = 1'b0;
    case (mode_q)
      RM_RNE:  inc = g_q & (r_q | s_q | frac_q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (g_q | r_q | s_q) & ~sign_q;
      RM_RDN:  inc = (g_q | r_q | s_q) & sign_q;
      default: inc = 1'b0;
    endcase
  end
  assign {carry, frac_rnd} = {1'b0, frac_q} + (MAN_W + 1)'(inc);
  assign exp_rnd = exp_q + EW'(carry);
  assign ovf     = !exp_rnd[EW-1] && (exp_rnd >= EW'(EMAX));
  assign unf     = exp_rnd[EW-1] || (exp_rnd == '0);
  assign to_inf  = (mode_q == RM_RNE) || ((mode_q == RM_RUP) && !sign_q)
                   || ((mode_q == RM_RDN) && sign_q);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= RM_RNE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      frac_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      res_q   <= '0;
      exc_q   <= EXC_NORMAL;
      dout_q  <= '0;
      xo_q    <= EXC_NORMAL;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      dout_q  <= dout_d;
      xo_q    <= xo_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    g_d       = g_q;
    r_d       = r_q;
    s_d       = s_q;
    res_d     = res_q;
    exc_d     = exc_q;
    dout_d    = dout_q;
    xo_d      = xo_q;
    dv_d      = dv_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dv_d = 1'b0;
        if (bus.Data_valid) begin
          a_d       = bus.Datain1;
          b_d       = bus.Datain2;
          mode_d    = rmode_t'(bus.Mode);
          mul_start = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        sign_d  = sa ^ sb;
        exp_d   = exp_sum;
        state_d = ST_DONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          res_d = QNAN;
          exc_d = EXC_NAN;
        end else if (a_inf || b_inf) begin
          res_d = W'(fp_inf(sa ^ sb, EXP_W, MAN_W));
          exc_d = EXC_INF;
        end else if (a_zero || b_zero) begin
          res_d = {sa ^ sb, {(W - 1){1'b0}}};
          exc_d = EXC_ZERO;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_NORM;
      end
      ST_NORM: begin
        // Product is in [1,4); a set MSB means one extra exponent step.
        frac_d  = mul_prod[PW-1] ? mul_prod[PW-2 -: MAN_W] : mul_prod[PW-3 -: MAN_W];
        g_d     = mul_prod[PW-1] ? mul_prod[PW-2-MAN_W] : mul_prod[PW-3-MAN_W];
        r_d     = mul_prod[PW-1] ? mul_prod[PW-3-MAN_W] : mul_prod[PW-4-MAN_W];
        s_d     = mul_prod[PW-1] ? (|mul_prod[PW-4-MAN_W:0]) : (|mul_prod[PW-5-MAN_W:0]);
        exp_d   = exp_q + EW'(mul_prod[PW-1]);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        state_d = ST_DONE;
        if (ovf) begin
          res_d = to_inf ? W'(fp_inf(sign_q, EXP_W, MAN_W)) : W'(fp_max(sign_q, EXP_W, MAN_W));
          exc_d = EXC_INF;
        end else if (unf) begin
          res_d = {sign_q, {(W - 1){1'b0}}};
          exc_d = EXC_UNDERFLOW;
        end else begin
          res_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
          exc_d = EXC_NORMAL;
        end
      end
      ST_DONE: begin
        // First DONE edge publishes; an already-dropped request yields a pulse.
        if (!dv_q) begin
          dv_d   = 1'b1;
          dout_d = res_q;
          xo_d   = exc_q;
          if (!bus.Data_valid) state_d = ST_IDLE;
        end else if (!bus.Data_valid) begin
          dv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.Dataout       = dout_q;
  assign bus.Dataout_valid = dv_q;
  assign bus.Exc           = xo_q;
  assign bus.Busy          = busy_q;
endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed checks of fp_mult_seq in binary32 and binary16 configurations.
module tb_fp_mult_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_mult_seq_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  fp_mult_seq_if #(.EXP_W(5), .MAN_W(10)) b16 ();

  fp_mult_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.CLK(clk), .RSTn(rst_n), .bus(b32));
  fp_mult_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.CLK(clk), .RSTn(rst_n), .bus(b16));

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic [31:0] res;
    logic [2:0]  exc;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] mode, input logic [31:0] res,
                              input logic [2:0] exc, input int lat);
    vec_t v;
    v.nm = nm; v.a = a; v.b = b; v.mode = mode; v.res = res; v.exc = exc; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic run32(input vec_t v);
    int cyc;
    @(negedge clk);
    b32.Datain1 = v.a; b32.Datain2 = v.b; b32.Mode = v.mode; b32.Data_valid = 1'b1;
    @(posedge clk); #1;
    check({v.nm, " busy"}, 64'(b32.Busy), 64'd1);
    b32.Datain1 = 32'hFFFF_FFFF; b32.Datain2 = 32'h1234_5678; b32.Mode = ~v.mode;
    cyc = 0;
    while (!b32.Dataout_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.nm, " latency"}, 64'(cyc), 64'(v.lat));
    check({v.nm, " data"}, 64'(b32.Dataout), 64'(v.res));
    check({v.nm, " exc"}, 64'(b32.Exc), 64'(v.exc));
    @(negedge clk);
    b32.Data_valid = 1'b0;
    @(posedge clk); #1;
    check({v.nm, " release"}, 64'({b32.Dataout_valid, b32.Busy}), 64'd0);
  endtask

  task automatic run16(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [2:0] exc, input int lat);
    int cyc;
    @(negedge clk);
    b16.Datain1 = a; b16.Datain2 = b; b16.Mode = 2'b00; b16.Data_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!b16.Dataout_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(lat));
    check({nm, " data"}, 64'(b16.Dataout), 64'(res));
    check({nm, " exc"}, 64'(b16.Exc), 64'(exc));
    @(negedge clk);
    b16.Data_valid = 1'b0;
    @(posedge clk); #1;
    check({nm, " release"}, 64'(b16.Dataout_valid), 64'd0);
  endtask

  initial begin
    vecs.push_back(mk("pos_mul",   32'h4030_0000, 32'h40B0_0000, 2'b00, 32'h4172_0000, 3'b000, 28));
    vecs.push_back(mk("neg_mul",   32'hC030_0000, 32'h40B0_0000, 2'b00, 32'hC172_0000, 3'b000, 28));
    vecs.push_back(mk("inf_x_0",   32'h7F80_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 3'b011, 2));
    vecs.push_back(mk("ninf_x_2",  32'hFF80_0000, 32'h4000_0000, 2'b00, 32'hFF80_0000, 3'b100, 2));
    vecs.push_back(mk("nan_x_1",   32'h7FC0_0000, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 3'b011, 2));
    vecs.push_back(mk("ovf_rne",   32'h7F00_0000, 32'h4000_0000, 2'b00, 32'h7F80_0000, 3'b100, 28));
    vecs.push_back(mk("ovf_rtz",   32'h7F00_0000, 32'h4000_0000, 2'b01, 32'h7F7F_FFFF, 3'b100, 28));
    vecs.push_back(mk("unf",       32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0000_0000, 3'b010, 28));
    vecs.push_back(mk("nzero",     32'h8000_0000, 32'h3F80_0000, 2'b00, 32'h8000_0000, 3'b001, 2));
    vecs.push_back(mk("rnd_rne",   32'h3F80_0001, 32'h3F80_0001, 2'b00, 32'h3F80_0002, 3'b000, 28));
    vecs.push_back(mk("rnd_rup",   32'h3F80_0001, 32'h3F80_0001, 2'b10, 32'h3F80_0003, 3'b000, 28));
    vecs.push_back(mk("rnd_rdn",   32'h3F80_0001, 32'h3F80_0001, 2'b11, 32'h3F80_0002, 3'b000, 28));
    vecs.push_back(mk("norm_shift",32'h3FC0_0000, 32'h3FC0_0000, 2'b00, 32'h4010_0000, 3'b000, 28));
    vecs.push_back(mk("cy_rne",    32'h3FB5_04F3, 32'h3FB5_04F3, 2'b00, 32'h3FFF_FFFF, 3'b000, 28));
    vecs.push_back(mk("cy_rup",    32'h3FB5_04F3, 32'h3FB5_04F3, 2'b10, 32'h4000_0000, 3'b000, 28));
    vecs.push_back(mk("novf_rup",  32'h7F00_0000, 32'hC000_0000, 2'b10, 32'hFF7F_FFFF, 3'b100, 28));
    vecs.push_back(mk("novf_rdn",  32'h7F00_0000, 32'hC000_0000, 2'b11, 32'hFF80_0000, 3'b100, 28));

    b32.Datain1 = '0; b32.Datain2 = '0; b32.Mode = 2'b00; b32.Data_valid = 1'b0;
    b16.Datain1 = '0; b16.Datain2 = '0; b16.Mode = 2'b00; b16.Data_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs",
          64'({b32.Dataout, b32.Dataout_valid, b32.Exc, b32.Busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run32(vecs[i]);

    // Reset during the tenth MUL cycle discards the operation.
    @(negedge clk);
    b32.Datain1 = 32'h4030_0000; b32.Datain2 = 32'h40B0_0000; b32.Mode = 2'b00;
    b32.Data_valid = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midop reset dout", 64'(b32.Dataout), 64'd0);
    check("midop reset flags", 64'({b32.Dataout_valid, b32.Exc, b32.Busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; b32.Data_valid = 1'b0;
    @(posedge clk); #1;
    check("post reset idle", 64'({b32.Dataout_valid, b32.Busy}), 64'd0);
    run32(vecs[0]);

    // Request withdrawn before the result: single-cycle valid pulse.
    @(negedge clk);
    b32.Datain1 = 32'h0000_0000; b32.Datain2 = 32'h4000_0000; b32.Mode = 2'b00;
    b32.Data_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    b32.Data_valid = 1'b0;
    @(posedge clk); #1;
    check("pulse high", 64'(b32.Dataout_valid), 64'd1);
    check("pulse data", 64'({b32.Dataout, b32.Exc}), 64'({32'h0000_0000, 3'b001}));
    @(posedge clk); #1;
    check("pulse low", 64'({b32.Dataout_valid, b32.Busy}), 64'd0);

    run16("h_one_x_two", 16'h3C00, 16'h4000, 16'h4000, 3'b000, 15);
    run16("h_inf_x_0",   16'h7C00, 16'h0000, 16'h7E00, 3'b011, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point multiplier controller for the FPU datapath.
- Operands and result use the same four-phase valid handshake as the adder controller.
- Mantissas are multiplied by an iterative shift-add engine.
- Performs exception classification, normalisation, selectable rounding, and overflow/underflow handling.
- Default configuration is binary32; other EXP_W/MAN_W pairs (e.g. binary16) are supported unchanged.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1 is derived internally.
MAN_W, 23, stored fraction width; operand/result width W = 1+EXP_W+MAN_W.

Ports:
CLK  in  1  clock; all state updates on posedge.
RSTn  in  1  reset; synchronous and active-low.
Datain1  in  W  operand A {sign, exp, frac}.
Datain2  in  W  operand B.
Data_valid  in  1  request; held high until Dataout_valid seen.
Mode  in  2  rounding: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
Dataout  out  W  product.
Dataout_valid  out  1  result valid; held until Data_valid low.
Exc  out  3  000 normal, 001 zero result, 010 underflow flushed, 011 NaN, 100 infinity/overflow.
Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: on posedge with RSTn=0, FSM goes to IDLE and Dataout, Dataout_valid, Exc, Busy all go to 0. This applies mid-operation too; any in-flight operation is discarded with no output.
- States: IDLE, CHECK, MUL, NORM, ROUND, DONE.
- IDLE: when Data_valid=1, capture Datain1, Datain2 and Mode on that edge (E0), then go to CHECK. Later input changes are ignored until the next IDLE.
- CHECK (edge E1): classify both operands. Exp=0 counts as zero; subnormal inputs are flushed to zero. Exp all-ones with frac≠0 is NaN; with frac=0 it is Inf.
  - NaN operand, or Inf×0 → canonical qNaN {0, ones, 1, zeros}, Exc=011.
  - Inf×finite nonzero → signed Inf, Exc=100.
  - 0×finite → signed zero, Exc=001.
  - Any special case goes directly to DONE. Dataout_valid rises after E2, i.e. latency 2.
- MUL: significands {1,frac} (MAN_W+1 bits) multiplied LSB-first, one partial product per cycle. Runs MAN_W+1 cycles into a 2·MAN_W+2-bit product.
- Exponent sum: eA+eB-BIAS in an EXP_W+2-bit signed register.
- NORM: if product MSB=1, shift right by one and exp+1. Extract MAN_W fraction bits plus guard, round, and sticky (OR of the rest).
- ROUND, per Mode:
  - RNE increments on G&(R|S|lsb).
  - RTZ never increments.
  - Directed modes increment when (G|R|S) and sign matches the direction.
  - Fraction carry-out: fraction becomes 0, exp+1.
- Overflow (exp ≥ 2^EXP_W-1 after rounding): Exc=100. Result is Inf for RNE and for the directed mode toward the sign; otherwise max finite {s, ones-1, ones}.
- Underflow (exp ≤ 0): signed zero, Exc=010.
- Sign is always sA^sB, except for NaN.
- Normal latency: Dataout_valid rises after edge E(MAN_W+5), i.e. 28 cycles for binary32.
- DONE: Dataout, Exc and Dataout_valid=1 held stable. Leave for IDLE on the first edge with Data_valid=0.
  - If Data_valid dropped early, Dataout_valid is a 1-cycle pulse.
  - A new request is only accepted in IDLE, so there are no back-to-back captures.

Decomposition:
- Shared package fpu_pkg:
  - exc_t enum, with codes shared by exceptionChecker.
  - rmode_t enum.
  - FSM state enum.
  - canonical-NaN/Inf construction functions, parametrised by EXP_W and MAN_W.
- One sub-module, seq_mant_mult: start/done shift-add engine, width MAN_W+1.

Test Plan:
1. 0x40300000 (2.75) × 0x40B00000 (5.5), RNE → 0x41720000, Exc=000, Dataout_valid exactly 28 cycles after capture edge. Repeat with 0xC0300000 → 0xC1720000.
2. 0x7F800000 × 0x00000000 → 0x7FC00000, Exc=011, latency 2. Then 0xFF800000 × 0x40000000 → 0xFF800000, Exc=100.
3. 0x7F000000 × 0x40000000: Mode=00 → 0x7F800000, Exc=100; Mode=01 → 0x7F7FFFFF, Exc=100.
4. 0x00800000 × 0x3F000000 → 0x00000000, Exc=010. Then 0x80000000 × 0x3F800000 → 0x80000000, Exc=001.
5. 0x3F800001 squared: Mode=00 → 0x3F800002, Mode=10 → 0x3F800003, Mode=11 → 0x3F800002.
6. Handshake/reset:
   - RSTn=0 at MUL cycle 10 → all outputs 0 next edge, FSM in IDLE, next request computes correctly.
   - Data_valid dropped at E3 → single-cycle Dataout_valid pulse.
   - EXP_W=5, MAN_W=10: 0x3C00 × 0x4000 → 0x4000, latency 15.
